// File: rtl/tt_sweep_collector_pkg.sv
// Shared types and constants for the truth-table sweep collector.
// Holds the FSM state type, the legal parameter ranges and the table width helper.
package tt_sweep_collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FN_LAT_MIN = 0;
  localparam int FN_LAT_MAX = 3;
  localparam int NIN_MIN    = 2;
  localparam int NIN_MAX    = 8;

  function automatic int tt_width(input int nin);
    return 1 << nin;
  endfunction

endpackage

// File: rtl/tt_idx_delay.sv
// Delays the swept index and its capture-valid flag by FN_LAT cycles so that
// each fn_out sample lands at the table entry of the vector that produced it.
module tt_idx_delay
  import tt_sweep_collector_pkg::*;
#(
  parameter int NIN    = 7,
  parameter int FN_LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NIN-1:0] idx,
  input  logic           vld,
  output logic [NIN-1:0] idx_d,
  output logic           vld_d
);

  if (FN_LAT == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign idx_d = idx;
    assign vld_d = vld;
  end else begin : g_pipe
    logic [NIN-1:0]    idx_p [FN_LAT];
    logic [FN_LAT-1:0] vld_p;

    // Only the valid chain is reset; stale indices are harmless without it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= vld;
        for (int i = 1; i < FN_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      idx_p[0] <= idx;
      for (int i = 1; i < FN_LAT; i++) idx_p[i] <= idx_p[i-1];
    end

    assign idx_d = idx_p[FN_LAT-1];
    assign vld_d = vld_p[FN_LAT-1];
  end

endmodule

// File: rtl/tt_sweep_collector.sv
// Sweeps all 2**NIN input vectors through an external function and collects
// its outputs into a truth table with a running popcount and valid/ready result.
module tt_sweep_collector
  import tt_sweep_collector_pkg::*;
#(
  parameter int NIN    = 7,
  parameter int FN_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [NIN-1:0]           x,
  input  logic                     fn_out,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [tt_width(NIN)-1:0] tt,
  output logic [NIN:0]             ones,
  output logic                     balanced
);

  localparam int             TT_W       = tt_width(NIN);
  localparam logic [NIN-1:0] X_LAST     = '1;
  localparam logic [1:0]     DRAIN_LAST = (FN_LAT == 0) ? 2'd0 : 2'(FN_LAT - 1);
  localparam logic [NIN:0]   HALF       = (NIN+1)'(TT_W / 2);

  if (FN_LAT < FN_LAT_MIN || FN_LAT > FN_LAT_MAX || NIN < NIN_MIN || NIN > NIN_MAX) begin : g_bad_param
    $error("tt_sweep_collector: NIN or FN_LAT outside legal range");
  end

  state_t         state;
  logic [1:0]     drain_cnt;
  logic           sweep_vld;
  logic [NIN-1:0] idx_d;
  logic           vld_d;

  assign sweep_vld = (state == SWEEP);

  tt_idx_delay #(
    .NIN    (NIN),
    .FN_LAT (FN_LAT)
  ) u_idx_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (x),
    .vld   (sweep_vld),
    .idx_d (idx_d),
    .vld_d (vld_d)
  );

  // ones is NIN+1 bits wide so the all-ones function reaches 2**NIN exactly.
  assign balanced = (ones == HALF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      tt        <= '0;
      ones      <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      drain_cnt <= '0;
    end else begin
      // vld_d is only high in SWEEP/DRAIN, so capture never fights the IDLE clear.
      if (vld_d) begin
        tt[idx_d] <= fn_out;
        ones      <= ones + {{NIN{1'b0}}, fn_out};
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SWEEP;
            busy  <= 1'b1;
            x     <= '0;
            tt    <= '0;
            ones  <= '0;
          end
        end
        SWEEP: begin
          if (x == X_LAST) begin
            drain_cnt <= '0;
            if (FN_LAT == 0) begin
              state     <= DONE;
              busy      <= 1'b0;
              res_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            x <= x + NIN'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            x         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_collector.sv
// Scoreboard bench: three collectors (FN_LAT 0,1,2) sweep shared random and
// fixed functions; expected tables come from enumerating the function directly.
module tb_tt_sweep_collector;

  localparam int NIN = 7;
  localparam int TW  = 128;
  localparam int NI  = 3;

  typedef struct {
    logic [TW-1:0] tt;
    logic [NIN:0]  ones;
    int            due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic [NIN-1:0] x_w    [NI];
  logic           busy_w [NI];
  logic           val_w  [NI];
  logic           bal_w  [NI];
  logic [TW-1:0]  tt_w   [NI];
  logic [NIN:0]   ones_w [NI];

  int            fsel     = 0;
  logic [TW-1:0] rtab     = '0;
  int            cyc      = 0;
  int            checks   = 0;
  int            failures = 0;
  int            pending  = 0;
  bit            hold5    = 1'b0;
  exp_t          cur;
  event          issued;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic fnc(input int fs, input logic [TW-1:0] tab, input logic [NIN-1:0] v);
    case (fs)
      0:       return 1'b0;
      1:       return v[0];
      2:       return &v;
      3:       return $countones(v) >= 4;
      4:       return tab[v];
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string nm, input int inst, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%h exp=%h (t=%0t)", nm, inst, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_i
    logic           rdy = 1'b0;
    logic           fo;
    logic [NIN-1:0] xd [3];
    exp_t           q [$];

    // Registered model of a function with g cycles of latency.
    always @(posedge clk) begin
      xd[0] <= x_w[g];
      xd[1] <= xd[0];
      xd[2] <= xd[1];
    end
    if (g == 0) begin : g_c
      assign fo = fnc(fsel, rtab, x_w[g]);
    end else begin : g_r
      assign fo = fnc(fsel, rtab, xd[g-1]);
    end

    tt_sweep_collector #(
      .NIN    (NIN),
      .FN_LAT (g)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .x         (x_w[g]),
      .fn_out    (fo),
      .busy      (busy_w[g]),
      .res_valid (val_w[g]),
      .res_ready (rdy),
      .tt        (tt_w[g]),
      .ones      (ones_w[g]),
      .balanced  (bal_w[g])
    );

    initial forever begin
      exp_t n;
      @(issued);
      n     = cur;
      n.due = cur.due + g;
      q.push_back(n);
    end

    initial begin
      exp_t e;
      int   h;
      int   ph;
      h  = 0;
      ph = 0;
      e  = '{tt: '0, ones: '0, due: 0};
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pending -= q.size();
          q.delete();
          ph  = 0;
          rdy = 1'b0;
        end else if (ph == 0) begin
          if (hold5) rdy = 1'b0;
          if (val_w[g]) begin
            if (q.size() == 0) begin
              chk("unexpected_valid", g, TW'(val_w[g]), TW'(0));
            end else begin
              e = q[0];
              chk("latency", g, TW'(cyc), TW'(e.due));
              chk("tt", g, tt_w[g], e.tt);
              chk("ones", g, TW'(ones_w[g]), TW'(e.ones));
              chk("balanced", g, TW'(bal_w[g]), TW'(e.ones == 8'd64));
              chk("busy_done", g, TW'(busy_w[g]), TW'(0));
              chk("x_hold", g, TW'(x_w[g]), TW'(127));
              ph = 1;
              if (!rdy) h = hold5 ? 5 : $urandom_range(1, 5);
            end
          end else if (q.size() != 0) begin
            if (cyc == q[0].due - 1) chk("busy_sweep", g, TW'(busy_w[g]), TW'(1));
            if (cyc > q[0].due) begin
              chk("result_timeout", g, TW'(cyc), TW'(q[0].due));
              void'(q.pop_front());
              pending--;
            end
          end
        end else begin
          if (rdy) begin
            chk("valid_after_hs", g, TW'(val_w[g]), TW'(0));
            chk("busy_after_hs", g, TW'(busy_w[g]), TW'(0));
            chk("x_idle", g, TW'(x_w[g]), TW'(0));
            void'(q.pop_front());
            pending--;
            ph  = 0;
            rdy = (!hold5 && $urandom_range(0, 2) == 0);
          end else begin
            chk("valid_hold", g, TW'(val_w[g]), TW'(1));
            chk("tt_stable", g, tt_w[g], e.tt);
            chk("ones_stable", g, TW'(ones_w[g]), TW'(e.ones));
            h--;
            if (h <= 0) rdy = 1'b1;
          end
        end
      end
    end
  end

  task automatic check_reset_state();
    for (int k = 0; k < NI; k++) begin
      chk("rst_x", k, TW'(x_w[k]), TW'(0));
      chk("rst_tt", k, tt_w[k], TW'(0));
      chk("rst_ones", k, TW'(ones_w[k]), TW'(0));
      chk("rst_busy", k, TW'(busy_w[k]), TW'(0));
      chk("rst_valid", k, TW'(val_w[k]), TW'(0));
      chk("rst_balanced", k, TW'(bal_w[k]), TW'(0));
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    while (pending != 0 && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (pending != 0) begin
      chk("drain_timeout", 0, TW'(pending), TW'(0));
      pending = 0;
    end
  endtask

  task automatic issue(input int fs, input bit hold, input bit pulse40, input bit rst60);
    logic [TW-1:0] t;
    int            base;
    wait_idle();
    @(negedge clk);
    hold5 = hold;
    fsel  = fs;
    if (fs == 4) rtab = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < TW; i++) t[i] = fnc(fs, rtab, NIN'(i));
    cur.tt   = t;
    cur.ones = (NIN+1)'($countones(t));
    cur.due  = cyc + TW + 1;
    base     = cyc;
    start    = 1'b1;
    pending += NI;
    ->issued;
    @(negedge clk);
    start = 1'b0;
    if (pulse40) begin
      while (cyc < base + 40) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (rst60) begin
      while (cyc < base + 60) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_state();
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    issue(0, 1'b0, 1'b0, 1'b0);
    issue(1, 1'b0, 1'b0, 1'b0);
    issue(2, 1'b0, 1'b0, 1'b0);
    issue(3, 1'b1, 1'b0, 1'b0);
    issue(5, 1'b0, 1'b0, 1'b0);
    issue(4, 1'b0, 1'b1, 1'b0);
    issue(1, 1'b0, 1'b0, 1'b1);
    issue(4, 1'b0, 1'b0, 1'b0);
    issue(3, 1'b0, 1'b0, 1'b1);
    issue(3, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) issue(4, 1'b0, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
